branch_issue_ctrl: RTL and testbench
====================================

BRANCH_ISSUE_CTRL -- requirements
Module: branch_issue_ctrl

Interface
REQ-001 Parameter TAG_W, default 4, SHALL set the width of the reorder/instruction tag carried with each branch.
REQ-002 Parameter XLEN, default 16, SHALL set the operand, PC and immediate width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid_i  input  2  per issue slot, a branch request is presented; slot 0 is older than slot 1 within one bundle.
REQ-006 req_ready_o  output  2  per slot, the request is accepted when valid and ready are both high on a clock edge.
REQ-007 req_a_i, req_b_i, req_pc_i, req_imm_i  input  2xXLEN each  per-slot compare operands, PC and offset.
REQ-008 req_tag_i  input  2xTAG_W  per-slot instruction tag.
REQ-009 flush_i  input  1  external pipeline flush.
REQ-010 res_valid_o  output  1  resolution result valid, one-cycle pulse per branch.
REQ-011 res_taken_o  output  1  branch taken (a == b).
REQ-012 res_target_o  output  XLEN  next PC for the resolved branch.
REQ-013 res_tag_o  output  TAG_W  tag of the resolved branch.

Function
REQ-014 Each slot SHALL own one holding entry (full bit, age bit, payload); req_ready_o[k] SHALL equal ~full[k] and SHALL be forced 0 in RECOVER and while flush_i is high.
REQ-015 FSM states SHALL be IDLE (no entry full), BUSY (at least one entry full), and RECOVER (one-cycle bubble after a taken branch).
REQ-016 Transitions: IDLE->BUSY on any acceptance; BUSY->IDLE when the last entry issues with no acceptance that cycle; BUSY->RECOVER on a taken issue; RECOVER->IDLE unconditionally after one cycle; any state->IDLE on flush_i.
REQ-017 In BUSY, exactly one full entry SHALL issue to the shared comparator per cycle, and the oldest SHALL be selected.
REQ-018 Age rule: an entry accepted in an earlier cycle is older than an entry accepted later; for same-cycle acceptance, slot 0 is older.
REQ-019 Issue SHALL be combinationally from the held entry; an entry accepted at edge N SHALL issue no earlier than cycle N+1.
REQ-020 The result SHALL be registered, with res_* valid in the cycle after issue, giving a fixed 2-cycle accept-to-result minimum latency.
REQ-021 res_taken_o SHALL be 1 iff a == b; res_target_o SHALL be (pc + imm) mod 2^XLEN when taken, else pc.
REQ-022 On a taken issue, every other held entry is younger and SHALL be discarded without producing a result, and no request SHALL be accepted in that cycle.
REQ-023 The issuing entry's full bit SHALL clear in the issue cycle, so the slot may accept a new request at the same edge if not taken.
REQ-024 flush_i SHALL clear all entries, suppress res_valid_o for any issue in the same cycle, and take priority over acceptance and issue.
REQ-025 A result already registered (res_valid_o high) when flush_i rises SHALL still be presented that cycle.
REQ-026 Simultaneous acceptance in both slots in IDLE SHALL issue slot 0 first, then slot 1 the following cycle if slot 0 is not taken.

Reset
REQ-027 With rst_n low at a clock edge, the block SHALL clear full and age bits, set state IDLE, set res_valid_o, res_taken_o, res_target_o and res_tag_o to 0, and hold req_ready_o at 0 during reset.
REQ-028 Reset mid-operation SHALL discard all held entries and any pending result, with no result emitted afterwards.

Structure
REQ-029 The FSM state encoding and the XLEN/TAG_W defaults SHALL live in the shared processor package.
REQ-030 The equality compare and target adder SHALL be one combinational sub-module, branch_unit, instantiated once and shared by both slots.

Verification
REQ-031 Single branch, slot 0: a=5, b=5, pc=0x0010, imm=0x0008, tag=3 -> res_valid_o two cycles after acceptance, taken=1, target=0x0018, tag=3.
REQ-032 Both slots in the same cycle, slot 0 not taken (a=1, b=2, pc=0x0020), slot 1 taken (pc=0x0021, imm=4) -> results on consecutive cycles: target 0x0020 then 0x0025, in tag order.
REQ-033 Both slots in the same cycle, slot 0 taken -> one result only, slot 1 discarded, req_ready_o=00 for one RECOVER cycle.
REQ-034 Wrap: pc=0xFFFC, imm=0x0008, a==b -> target=0x0004.
REQ-035 flush_i asserted while both entries are full and one is issuing -> no res_valid_o on the next cycle, state IDLE, req_ready_o=11 the cycle after the flush deasserts.
REQ-036 rst_n low for one cycle with slot 1 full -> all outputs 0, and no result emitted afterwards.

Source files
------------

// File: rtl/branch_issue_ctrl_pkg.sv
// Shared processor package: default widths and the issue-controller state encoding.
package branch_issue_ctrl_pkg;

  localparam int XLEN_DEF  = 16;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

endpackage

// File: rtl/branch_issue_ctrl_branch_unit.sv
// Combinational branch resolution: equality compare and next-PC selection.
module branch_unit #(
  parameter int XLEN = 16
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o
);

  always_comb begin
    taken_o  = (a_i == b_i);
    target_o = taken_o ? (pc_i + imm_i) : pc_i;
  end

endmodule

// File: rtl/branch_issue_ctrl.sv
// Two-slot branch issue controller: holds one branch per slot, issues the oldest
// to a shared branch unit each cycle, registers the result and squashes younger work.
module branch_issue_ctrl
  import branch_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][XLEN-1:0]  req_a_i,
  input  logic [1:0][XLEN-1:0]  req_b_i,
  input  logic [1:0][XLEN-1:0]  req_pc_i,
  input  logic [1:0][XLEN-1:0]  req_imm_i,
  input  logic [1:0][TAG_W-1:0] req_tag_i,
  input  logic                  flush_i,
  output logic                  res_valid_o,
  output logic                  res_taken_o,
  output logic [XLEN-1:0]       res_target_o,
  output logic [TAG_W-1:0]      res_tag_o
);

  state_e                state_q, state_d;
  logic [1:0]            full_q, full_d;
  logic [1:0]            age_q, age_d;
  logic [1:0][XLEN-1:0]  a_q, a_d, b_q, b_d, pc_q, pc_d, imm_q, imm_d;
  logic [1:0][TAG_W-1:0] tag_q, tag_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_taken_q, res_taken_d;
  logic [XLEN-1:0]       res_target_q, res_target_d;
  logic [TAG_W-1:0]      res_tag_q, res_tag_d;

  logic                  issue;
  logic                  issue_sel;
  logic [1:0]            issue_oh;
  logic [1:0]            full_rem;
  logic [1:0]            accept;
  logic                  block_acc;
  logic                  bu_taken;
  logic [XLEN-1:0]       bu_target;

  // age_q[k] marks entry k as the older one when both entries are held
  always_comb begin
    issue_sel = (full_q == 2'b11) ? age_q[1] : full_q[1];
    issue     = (state_q == ST_BUSY) && (|full_q);
    issue_oh  = issue ? (issue_sel ? 2'b10 : 2'b01) : 2'b00;
  end

  branch_unit #(.XLEN(XLEN)) u_branch_unit (
    .a_i      (a_q[issue_sel]),
    .b_i      (b_q[issue_sel]),
    .pc_i     (pc_q[issue_sel]),
    .imm_i    (imm_q[issue_sel]),
    .taken_o  (bu_taken),
    .target_o (bu_target)
  );

  // The issuing entry frees its slot this cycle unless it squashes the pipeline
  always_comb begin
    full_rem    = full_q & ~issue_oh;
    block_acc   = !rst_n || flush_i || (state_q == ST_RECOVER) || (issue && bu_taken);
    req_ready_o = block_acc ? 2'b00 : ~full_rem;
    accept      = req_valid_i & req_ready_o;
  end

  always_comb begin
    full_d = full_rem | accept;
    a_d    = a_q;
    b_d    = b_q;
    pc_d   = pc_q;
    imm_d  = imm_q;
    tag_d  = tag_q;
    for (int k = 0; k < 2; k++) begin
      if (accept[k]) begin
        a_d[k]   = req_a_i[k];
        b_d[k]   = req_b_i[k];
        pc_d[k]  = req_pc_i[k];
        imm_d[k] = req_imm_i[k];
        tag_d[k] = req_tag_i[k];
      end
    end

    if (full_rem == 2'b11)             age_d = age_q;
    else if (full_rem[0] && accept[1]) age_d = 2'b01;
    else if (full_rem[1] && accept[0]) age_d = 2'b10;
    else if (accept == 2'b11)          age_d = 2'b01;
    else                               age_d = full_d;

    if (flush_i || (issue && bu_taken)) begin
      full_d = 2'b00;
      age_d  = 2'b00;
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (|accept) state_d = ST_BUSY;
      ST_BUSY: begin
        if (issue && bu_taken) state_d = ST_RECOVER;
        else if (~|full_d)     state_d = ST_IDLE;
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;

    res_valid_d  = issue && !flush_i;
    res_taken_d  = issue ? bu_taken : res_taken_q;
    res_target_d = issue ? bu_target : res_target_q;
    res_tag_d    = issue ? tag_q[issue_sel] : res_tag_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      full_q       <= '0;
      age_q        <= '0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
      res_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      age_q        <= age_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
      res_tag_q    <= res_tag_d;
    end
  end

  // Payload is qualified by full_q, so it needs no reset
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    pc_q  <= pc_d;
    imm_q <= imm_d;
    tag_q <= tag_d;
  end

  assign res_valid_o  = res_valid_q;
  assign res_taken_o  = res_taken_q;
  assign res_target_o = res_target_q;
  assign res_tag_o    = res_tag_q;

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// Scoreboard bench for branch_issue_ctrl: directed scenarios followed by random traffic
// checked against an age-ordered queue model of the held branches.
module tb_branch_issue_ctrl;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [3:0]  tag;
  } br_t;

  typedef struct packed {
    br_t  p;
    logic slot;
  } ent_t;

  typedef struct packed {
    int          cyc;
    logic        tk;
    logic [15:0] tgt;
    logic [3:0]  tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid_i = 2'b00;
  logic [1:0]       req_ready_o;
  logic [1:0][15:0] req_a_i = '0, req_b_i = '0, req_pc_i = '0, req_imm_i = '0;
  logic [1:0][3:0]  req_tag_i = '0;
  logic             flush_i = 1'b0;
  logic             res_valid_o, res_taken_o;
  logic [15:0]      res_target_o;
  logic [3:0]       res_tag_o;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  ent_t held[$];
  exp_t sb[$];
  logic recover = 1'b0;
  logic chk_rst = 1'b0;

  branch_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_pc_i     (req_pc_i),
    .req_imm_i    (req_imm_i),
    .req_tag_i    (req_tag_i),
    .flush_i      (flush_i),
    .res_valid_o  (res_valid_o),
    .res_taken_o  (res_taken_o),
    .res_target_o (res_target_o),
    .res_tag_o    (res_tag_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expected result must appear exactly in its cycle; nothing else may appear
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        vectors++;
        if (res_valid_o !== 1'b1) begin
          miscompares++;
          $display("FAIL result_missing cyc=%0d got valid=%b want valid=1 tag=%0d", cyc, res_valid_o, e.tag);
        end else if ({res_taken_o, res_target_o, res_tag_o} !== {e.tk, e.tgt, e.tag}) begin
          miscompares++;
          $display("FAIL result_data cyc=%0d got tk=%b tgt=%h tag=%0d want tk=%b tgt=%h tag=%0d",
                   cyc, res_taken_o, res_target_o, res_tag_o, e.tk, e.tgt, e.tag);
        end
      end else if (res_valid_o === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL result_unexpected cyc=%0d got valid=1 tag=%0d want valid=0", cyc, res_tag_o);
      end
    end
  end

  function automatic br_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] pc,
                             input logic [15:0] imm, input logic [3:0] tag);
    br_t r;
    r.a = a; r.b = b; r.pc = pc; r.imm = imm; r.tag = tag;
    return r;
  endfunction

  function automatic br_t rnd_br();
    return mk(16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), 16'($urandom),
              16'($urandom), 4'($urandom));
  endfunction

  // One clock cycle: drive inputs, check ready against the model, advance the model
  task automatic cycle(input logic [1:0] v, input br_t s0, input br_t s1, input logic fl, input logic rn);
    logic [1:0] er;
    logic       iss, tk;
    ent_t       it, n;
    exp_t       e;
    @(negedge clk);
    rst_n = rn;
    flush_i = fl;
    req_valid_i = v;
    req_a_i[0] = s0.a;   req_a_i[1] = s1.a;
    req_b_i[0] = s0.b;   req_b_i[1] = s1.b;
    req_pc_i[0] = s0.pc; req_pc_i[1] = s1.pc;
    req_imm_i[0] = s0.imm; req_imm_i[1] = s1.imm;
    req_tag_i[0] = s0.tag; req_tag_i[1] = s1.tag;
    #1;
    if (chk_rst) begin
      vectors++;
      if ({res_valid_o, res_taken_o, res_target_o, res_tag_o} !== 22'd0) begin
        miscompares++;
        $display("FAIL reset_outputs got v=%b tk=%b tgt=%h tag=%h want all zero",
                 res_valid_o, res_taken_o, res_target_o, res_tag_o);
      end
    end
    chk_rst = !rn;

    iss = rn && !recover && (held.size() > 0);
    tk = 1'b0;
    it = '0;
    if (iss) begin
      it = held[0];
      tk = (it.p.a == it.p.b);
    end
    er = 2'b00;
    if (rn && !fl && !recover && !(iss && tk)) begin
      er = 2'b11;
      foreach (held[i]) if (!(iss && i == 0)) er[held[i].slot] = 1'b0;
    end
    vectors++;
    if (req_ready_o !== er) begin
      miscompares++;
      $display("FAIL ready cyc=%0d got %b want %b", cyc, req_ready_o, er);
    end

    if (!rn || fl) begin
      held.delete();
      recover = 1'b0;
    end else begin
      recover = 1'b0;
      if (iss) begin
        e.cyc = cyc + 1;
        e.tk  = tk;
        e.tgt = tk ? 16'((32'(it.p.pc) + 32'(it.p.imm)) % 32'h10000) : it.p.pc;
        e.tag = it.p.tag;
        sb.push_back(e);
        if (tk) begin
          held.delete();
          recover = 1'b1;
        end else begin
          void'(held.pop_front());
        end
      end
      if (v[0] && er[0]) begin n.p = s0; n.slot = 1'b0; held.push_back(n); end
      if (v[1] && er[1]) begin n.p = s1; n.slot = 1'b1; held.push_back(n); end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    br_t z;
    z = '0;
    cycle(2'b00, z, z, 1'b0, 1'b0);
    cycle(2'b00, z, z, 1'b0, 1'b0);
    idle(1);

    // Single taken branch in slot 0
    cycle(2'b01, mk(16'd5, 16'd5, 16'h0010, 16'h0008, 4'd3), z, 1'b0, 1'b1);
    idle(3);
    // Same-cycle pair: older not taken, younger taken
    cycle(2'b11, mk(16'd1, 16'd2, 16'h0020, 16'h0010, 4'd1),
                 mk(16'd7, 16'd7, 16'h0021, 16'h0004, 4'd2), 1'b0, 1'b1);
    idle(4);
    // Same-cycle pair: older taken squashes younger
    cycle(2'b11, mk(16'd4, 16'd4, 16'h0100, 16'h0020, 4'd5),
                 mk(16'd1, 16'd1, 16'h0200, 16'h0002, 4'd6), 1'b0, 1'b1);
    idle(4);
    // Target wraps modulo 2^16
    cycle(2'b01, mk(16'd9, 16'd9, 16'hFFFC, 16'h0008, 4'd7), z, 1'b0, 1'b1);
    idle(3);
    // Flush while both held and one issuing
    cycle(2'b11, mk(16'd1, 16'd2, 16'h0300, 16'h0004, 4'd8),
                 mk(16'd3, 16'd2, 16'h0400, 16'h0004, 4'd9), 1'b0, 1'b1);
    cycle(2'b00, z, z, 1'b1, 1'b1);
    idle(3);
    // Flush arriving while a result is already registered
    cycle(2'b10, z, mk(16'd2, 16'd2, 16'h0500, 16'h0010, 4'd10), 1'b0, 1'b1);
    idle(1);
    cycle(2'b00, z, z, 1'b1, 1'b1);
    idle(2);
    // Reset with slot 1 still held
    cycle(2'b11, mk(16'd0, 16'd1, 16'h0600, 16'h0004, 4'd11),
                 mk(16'd2, 16'd2, 16'h0700, 16'h0004, 4'd12), 1'b0, 1'b1);
    cycle(2'b00, z, z, 1'b0, 1'b0);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      cycle(2'($urandom_range(0, 3)), rnd_br(), rnd_br(),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) != 0));
    end
    idle(4);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL pending_results got %0d outstanding want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
